// File: rtl/melody_pkg.sv
// Shared definitions for the melody path: sequencer state encoding, tempo
// codes and default melody dimensions. The note mux and the step sequencer
// both use these defaults, so they always agree on the melody length.
package melody_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Tempo codes. Code 2'b11 is unassigned and plays at the base rate.
  localparam logic [1:0] TEMPO_BASE = 2'b00;
  localparam logic [1:0] TEMPO_SLOW = 2'b01;  // 2x step length
  localparam logic [1:0] TEMPO_FAST = 2'b10;  // step length / 2, floored

  localparam int DEF_STEP_TICKS = 12_500_000;  // 250 ms at 50 MHz
  localparam int DEF_NUM_STEPS  = 26;
  localparam int DEF_SEL_W      = 8;

endpackage

// File: rtl/tempo_tick_gen.sv
// Step-length timer.
//   clk, rst_n : clock, async active-low reset
//   tempo      : tempo code, applied every cycle (not latched)
//   clear      : force the counter to 0 (takes priority over hold)
//   hold       : freeze the counter
//   tick       : high in the cycle the counter reaches its terminal value;
//                the counter returns to 0 on the following edge
module tempo_tick_gen
  import melody_pkg::*;
#(
  parameter int STEP_TICKS = DEF_STEP_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] tempo,
  input  logic       clear,
  input  logic       hold,
  output logic       tick
);

  // One bit of headroom above what 2*STEP_TICKS-1 needs.
  localparam int CW = $clog2(2 * STEP_TICKS) + 1;

  logic [CW-1:0] cnt;
  logic [CW-1:0] period;
  logic          term;

  always_comb begin
    period = CW'(STEP_TICKS);
    case (tempo)
      TEMPO_SLOW: period = CW'(2 * STEP_TICKS);
      TEMPO_FAST: period = CW'(STEP_TICKS / 2);
      default:    period = CW'(STEP_TICKS);
    endcase
  end

  // >= rather than ==: if the tempo shortens mid-step and the counter is
  // already past the new end, the step ends now instead of wrapping around.
  assign term = (cnt >= period - CW'(1));
  assign tick = !clear && !hold && term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (!hold)  cnt <= term ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/melody_step_sequencer.sv
// Controllable step sequencer feeding the note mux.
//   clk, rst_n : clock, async active-low reset
//   start      : pulse, (re)start the melody at step 0
//   stop       : abort playback, back to idle (beats start)
//   pause      : level, freeze position while high
//   loop_en    : level, wrap to step 0 after the last step
//   tempo      : step-length code (see melody_pkg)
//   sel        : current step index
//   control    : 1 while playing; 0 tells the mux to output mute
//   step_stb   : one-cycle pulse on each step advance (including wraps)
//   done       : one-cycle pulse when the melody ends without looping
module melody_step_sequencer
  import melody_pkg::*;
#(
  parameter int STEP_TICKS = DEF_STEP_TICKS,
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int SEL_W      = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             loop_en,
  input  logic [1:0]       tempo,
  output logic [SEL_W-1:0] sel,
  output logic             control,
  output logic             step_stb,
  output logic             done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_STEPS - 1);

  state_e           state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic             stb_n, done_n;
  logic             clear, hold, tick;

  // Counter runs only while playing; it is zeroed in idle and on any
  // stop/start so a restart always gets a full first step.
  assign clear = (state == IDLE) || stop || start;
  assign hold  = (state != PLAY);

  tempo_tick_gen #(.STEP_TICKS(STEP_TICKS)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tempo (tempo),
    .clear (clear),
    .hold  (hold),
    .tick  (tick)
  );

  always_comb begin
    state_n = state;
    sel_n   = sel;
    stb_n   = 1'b0;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        sel_n = '0;
        if (start && !stop) state_n = PLAY;
      end
      PLAY, HOLD: begin
        if (stop) begin
          state_n = IDLE;
          sel_n   = '0;
        end else if (start) begin
          state_n = PLAY;
          sel_n   = '0;
        end else if (state == PLAY) begin
          if (tick) begin
            if (sel < LAST) begin
              sel_n = sel + SEL_W'(1);
              stb_n = 1'b1;
            end else if (loop_en) begin
              sel_n = '0;
              stb_n = 1'b1;
            end else begin
              state_n = IDLE;
              sel_n   = '0;
              done_n  = 1'b1;
            end
          end
          // Advance first, then pause; a finished melody stays idle.
          if (pause && state_n == PLAY) state_n = HOLD;
        end else if (!pause) begin
          state_n = PLAY;
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      control  <= 1'b0;
      step_stb <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      sel      <= sel_n;
      control  <= (state_n == PLAY);
      step_stb <= stb_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_melody_step_sequencer.sv
module tb_melody_step_sequencer;
  localparam int ST = 4;
  localparam int NS = 3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [1:0] tempo = 2'b00;
  logic [7:0] sel;
  logic       control, step_stb, done;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  melody_step_sequencer #(.STEP_TICKS(ST), .NUM_STEPS(NS), .SEL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .tempo(tempo), .sel(sel), .control(control),
    .step_stb(step_stb), .done(done)
  );

  // Reference model: st 0=idle 1=playing 2=paused; el = cycles already
  // spent playing the current step.
  typedef struct {
    int st; int sel; int el; bit stb; bit dn;
  } model_t;
  model_t m;

  function automatic int period_of(input logic [1:0] t);
    if (t == 2'b01) return 2 * ST;
    if (t == 2'b10) return ST / 2;
    return ST;
  endfunction

  function automatic model_t next_model(input model_t c, input logic s_start,
      input logic s_stop, input logic s_pause, input logic s_loop, input logic [1:0] s_tempo);
    model_t n;
    n = c; n.stb = 0; n.dn = 0;
    if (s_stop) begin n.st = 0; n.sel = 0; n.el = 0; end
    else if (s_start) begin n.st = 1; n.sel = 0; n.el = 0; end
    else if (c.st == 1) begin
      n.el = c.el + 1;
      if (n.el >= period_of(s_tempo)) begin
        n.el = 0;
        if (c.sel + 1 < NS) begin n.sel = c.sel + 1; n.stb = 1; end
        else if (s_loop) begin n.sel = 0; n.stb = 1; end
        else begin n.st = 0; n.sel = 0; n.dn = 1; end
      end
      if (n.st == 1 && s_pause) n.st = 2;
    end else if (c.st == 2 && !s_pause) n.st = 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{0, 0, 0, 1'b0, 1'b0};
    else        m <= next_model(m, start, stop, pause, loop_en, tempo);
  end

  logic [10:0] obs, expv;
  assign obs  = {control, step_stb, done, sel};
  assign expv = {(m.st == 1), m.stb, m.dn, m.sel[7:0]};

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    checks++;
    if (obs !== 11'd0) begin
      failures++; $display("FAIL reset got=%h want=%h", obs, 11'd0);
    end
    rst_n = 1'b1;
    cyc();
    checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_idle got=%h want=%h", obs, expv);
    end
  endtask

  task automatic test_single_pass();
    int nstb, ndone;
    nstb = 0; ndone = 0;
    loop_en = 0; tempo = 2'b00;
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL single_model cyc=%0d got=%h want=%h", i, obs, expv);
      end
      checks++;
      if (sel !== 8'((i < 12) ? i / 4 : 0) || done !== (i == 12)) begin
        failures++;
        $display("FAIL single_seq cyc=%0d got sel=%0d done=%0b want sel=%0d done=%0b",
                 i, sel, done, (i < 12) ? i / 4 : 0, (i == 12));
      end
      nstb += step_stb; ndone += done;
      cyc();
    end
    checks++;
    if (nstb != 2 || ndone != 1 || control !== 1'b0) begin
      failures++; $display("FAIL single_counts got stb=%0d done=%0d ctrl=%0b want 2 1 0",
                           nstb, ndone, control);
    end
  endtask

  task automatic test_loop();
    int nstb, ndone;
    nstb = 0; ndone = 0;
    loop_en = 1; start = 1; cyc(); start = 0;
    for (int i = 0; i < 56; i++) begin
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL loop_model cyc=%0d got=%h want=%h", i, obs, expv);
      end
      nstb += step_stb; ndone += done;
      cyc();
    end
    checks++;
    if (nstb != 13 || ndone != 0) begin
      failures++; $display("FAIL loop_counts got stb=%0d done=%0d want 13 0", nstb, ndone);
    end
    stop = 1; cyc(); stop = 0; loop_en = 0;
  endtask

  task automatic test_tempo();
    bit found;
    found = 0;
    tempo = 2'b01; start = 1; cyc(); start = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL tempo_slow cyc=%0d got=%h want=%h", i, obs, expv);
      end
      if (m.st == 1 && m.el == 5) found = 1; else cyc();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL tempo_wait got=timeout want=counter5");
    end
    tempo = 2'b10; cyc();
    checks++;
    if (step_stb !== 1'b1 || sel !== 8'd1) begin
      failures++; $display("FAIL tempo_switch got stb=%0b sel=%0d want 1 1", step_stb, sel);
    end
    for (int i = 0; i < 8; i++) begin
      cyc();
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL tempo_fast cyc=%0d got=%h want=%h", i, obs, expv);
      end
    end
    tempo = 2'b00;
  endtask

  task automatic test_pause();
    bit found;
    found = 0;
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m.st == 1 && m.sel == 1 && m.el == 2) found = 1; else cyc();
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL pause_wait got=timeout want=step1_count2");
    end
    pause = 1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      checks++;
      if (obs !== expv || sel !== 8'd1 || control !== 1'b0) begin
        failures++; $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, obs, expv);
      end
    end
    pause = 0;
    cyc();
    checks++;
    if (sel !== 8'd1 || control !== 1'b1) begin
      failures++; $display("FAIL pause_resume got sel=%0d ctrl=%0b want 1 1", sel, control);
    end
    cyc();
    checks++;
    if (sel !== 8'd2 || step_stb !== 1'b1) begin
      failures++; $display("FAIL pause_done got sel=%0d stb=%0b want 2 1", sel, step_stb);
    end
    stop = 1; cyc(); stop = 0;
  endtask

  task automatic test_stop_start();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 5; i++) cyc();
    stop = 1; start = 1; cyc(); stop = 0; start = 0;
    checks++;
    if (control !== 1'b0 || sel !== 8'd0 || done !== 1'b0) begin
      failures++; $display("FAIL stop_start got ctrl=%0b sel=%0d done=%0b want 0 0 0",
                           control, sel, done);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (obs !== expv || control !== 1'b0) begin
        failures++; $display("FAIL stop_idle cyc=%0d got=%h want=%h", i, obs, expv);
      end
    end
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (sel !== 8'((i < 4) ? 0 : 1) || control !== 1'b1) begin
        failures++; $display("FAIL restart cyc=%0d got sel=%0d ctrl=%0b want sel=%0d ctrl=1",
                             i, sel, control, (i < 4) ? 0 : 1);
      end
      cyc();
    end
  endtask

  task automatic test_async_reset();
    #3 rst_n = 0;
    #1;
    checks++;
    if (obs !== 11'd0) begin
      failures++; $display("FAIL async_reset got=%h want=%h", obs, 11'd0);
    end
    cyc();
    #3 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (obs !== expv || control !== 1'b0 || sel !== 8'd0) begin
        failures++; $display("FAIL post_reset cyc=%0d got=%h want=%h", i, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0)  pause = ~pause;
      if ($urandom_range(0, 49) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 19) == 0) tempo = 2'($urandom_range(0, 3));
      cyc();
      checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, expv);
      end
    end
    start = 0; stop = 0; pause = 0; loop_en = 0; tempo = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_loop();
    test_tempo();
    test_pause();
    test_stop_start();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
